// File: rtl/simplecpu_pkg.sv
// rtl/simplecpu_pkg.sv - shared opcodes, FSM state encoding and reset PC for simplecpu_core
package simplecpu_pkg;

   localparam logic [7:0] RESET_PC_DEFAULT = 8'h00;

   typedef enum logic [1:0] {
      ST_FETCH   = 2'd0,
      ST_OPERAND = 2'd1,
      ST_EXECUTE = 2'd2,
      ST_HALT    = 2'd3
   } state_t;

   typedef enum logic [3:0] {
      OP_NOP    = 4'h0,
      OP_LDA    = 4'h1,
      OP_LDB    = 4'h2,
      OP_ADD    = 4'h3,
      OP_SUB    = 4'h4,
      OP_AND    = 4'h5,
      OP_OR     = 4'h6,
      OP_XOR    = 4'h7,
      OP_OUT    = 4'h8,
      OP_IN     = 4'h9,
      OP_JMP    = 4'hA,
      OP_JZ     = 4'hB,
      OP_JC     = 4'hC,
      OP_RSVD_D = 4'hD,
      OP_RSVD_E = 4'hE,
      OP_HLT    = 4'hF
   } opcode_t;

   function automatic logic has_operand(input opcode_t op);
      return (op == OP_LDA) || (op == OP_LDB) || (op == OP_JMP) ||
             (op == OP_JZ)  || (op == OP_JC);
   endfunction

endpackage

// File: rtl/simplecpu_alu.sv
// rtl/simplecpu_alu.sv - combinational ALU for ADD/SUB/AND/OR/XOR; other opcodes pass A and carry through
module simplecpu_alu
   import simplecpu_pkg::*;
(
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   input  opcode_t    opcode_i,
   input  logic       c_i,
   output logic [7:0] result_o,
   output logic       c_o,
   output logic       z_o
);

   logic [8:0] sum;

   always_comb begin
      sum      = {1'b0, a_i} + {1'b0, b_i};
      result_o = a_i;
      c_o      = c_i;
      case (opcode_i)
         OP_ADD: {c_o, result_o} = sum;
         OP_SUB: begin
            result_o = a_i - b_i;
            c_o      = (a_i < b_i);
         end
         OP_AND: result_o = a_i & b_i;
         OP_OR:  result_o = a_i | b_i;
         OP_XOR: result_o = a_i ^ b_i;
         default: ;
      endcase
      z_o = (result_o == 8'd0);
   end

endmodule

// File: rtl/simplecpu_core.sv
// rtl/simplecpu_core.sv - 8-bit accumulator CPU with fetch/operand/execute FSM
// Optional SIMPLECPU_SINGLE_STEP_EN adds step_i: one rising edge fetches one instruction.
module simplecpu_core
   import simplecpu_pkg::*;
#(
   parameter logic [7:0] RESET_PC = RESET_PC_DEFAULT
)(
   input  logic       wb_clk_i,
   input  logic       wb_rst_n_i,
   input  logic       run_i,
`ifdef SIMPLECPU_SINGLE_STEP_EN
   input  logic       step_i,
`endif
   output logic [7:0] ram_addr_o,
   input  logic [7:0] ram_data_i,
   input  logic [7:0] io_in_i,
   output logic [7:0] io_out_o,
   output logic [7:0] a_o,
   output logic [7:0] b_o,
   output logic       flag_c_o,
   output logic       flag_z_o,
   output logic       halted_o
);

   state_t     state_q, state_d;
   logic [7:0] pc_q, pc_d;
   opcode_t    ir_q, ir_d;
   logic [7:0] opnd_q, opnd_d;
   logic [7:0] a_q, a_d;
   logic [7:0] b_q, b_d;
   logic       c_q, c_d;
   logic       z_q, z_d;
   logic [7:0] io_out_q, io_out_d;
   logic       fetch_en;
   logic [7:0] pc_inc;
   logic [7:0] alu_result;
   logic       alu_c;
   logic       alu_z;

`ifdef SIMPLECPU_SINGLE_STEP_EN
   logic step_q, step_d;
   logic step_prev_q, step_prev_d;

   assign step_d      = step_i;
   assign step_prev_d = step_q;
   assign fetch_en    = run_i | (step_q & ~step_prev_q);
`else
   assign fetch_en    = run_i;
`endif

   simplecpu_alu u_alu (
      .a_i      (a_q),
      .b_i      (b_q),
      .opcode_i (ir_q),
      .c_i      (c_q),
      .result_o (alu_result),
      .c_o      (alu_c),
      .z_o      (alu_z)
   );

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i) begin
         state_q     <= ST_FETCH;
         pc_q        <= RESET_PC;
         ir_q        <= OP_NOP;
         opnd_q      <= 8'd0;
         a_q         <= 8'd0;
         b_q         <= 8'd0;
         c_q         <= 1'b0;
         z_q         <= 1'b1;
         io_out_q    <= 8'd0;
`ifdef SIMPLECPU_SINGLE_STEP_EN
         step_q      <= 1'b0;
         step_prev_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         ir_q        <= ir_d;
         opnd_q      <= opnd_d;
         a_q         <= a_d;
         b_q         <= b_d;
         c_q         <= c_d;
         z_q         <= z_d;
         io_out_q    <= io_out_d;
`ifdef SIMPLECPU_SINGLE_STEP_EN
         step_q      <= step_d;
         step_prev_q <= step_prev_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_FETCH: begin
            if (fetch_en)
               state_d = has_operand(opcode_t'(ram_data_i[7:4])) ? ST_OPERAND : ST_EXECUTE;
         end
         ST_OPERAND: state_d = ST_EXECUTE;
         ST_EXECUTE: state_d = (ir_q == OP_HLT) ? ST_HALT : ST_FETCH;
         default:    state_d = ST_HALT;
      endcase
   end

   // Datapath next-state; pc_inc wraps naturally at 8 bits, including opcode->operand.
   always_comb begin
      pc_inc   = pc_q + 8'd1;
      pc_d     = pc_q;
      ir_d     = ir_q;
      opnd_d   = opnd_q;
      a_d      = a_q;
      b_d      = b_q;
      c_d      = c_q;
      z_d      = z_q;
      io_out_d = io_out_q;
      case (state_q)
         ST_FETCH: begin
            if (fetch_en) begin
               ir_d = opcode_t'(ram_data_i[7:4]);
               pc_d = pc_inc;
            end
         end
         ST_OPERAND: begin
            opnd_d = ram_data_i;
            pc_d   = pc_inc;
         end
         ST_EXECUTE: begin
            case (ir_q)
               OP_LDA: begin
                  a_d = opnd_q;
                  z_d = (opnd_q == 8'd0);
               end
               OP_LDB: b_d = opnd_q;
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                  a_d = alu_result;
                  c_d = alu_c;
                  z_d = alu_z;
               end
               OP_OUT: io_out_d = a_q;
               OP_IN: begin
                  a_d = io_in_i;
                  z_d = (io_in_i == 8'd0);
               end
               OP_JMP: pc_d = opnd_q;
               OP_JZ:  if (z_q) pc_d = opnd_q;
               OP_JC:  if (c_q) pc_d = opnd_q;
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   always_comb begin
      ram_addr_o = pc_q;
      io_out_o   = io_out_q;
      a_o        = a_q;
      b_o        = b_q;
      flag_c_o   = c_q;
      flag_z_o   = z_q;
      halted_o   = (state_q == ST_HALT);
   end

endmodule

// File: tb/tb_simplecpu_core.sv
// tb/tb_simplecpu_core.sv - scoreboard bench: ISA-level reference model, directed and random programs
module tb_simplecpu_core;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] pc;
      logic [7:0] out;
      logic       c;
      logic       z;
      int         cyc;
   } exp_t;

   typedef logic [7:0] byte_q_t[$];

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       run = 1'b0;
   logic [7:0] io_in = 8'd0;
   logic [7:0] mem  [0:255];
   logic [7:0] mem2 [0:255];

   logic [7:0] ram_addr, ram_data, io_out, a, b;
   logic       c, z, halted;
   logic [7:0] ram_addr2, ram_data2, io_out2, a2, b2;
   logic       c2, z2, halted2;
`ifdef SIMPLECPU_SINGLE_STEP_EN
   logic       step = 1'b0;
`endif

   exp_t exp_q[$];
   int   compared = 0;
   int   mismatched = 0;
   int   cyc_cnt = 0;
   bit   mon_active = 1'b0;
   bit   done = 1'b0;

   assign ram_data  = mem[ram_addr];
   assign ram_data2 = mem2[ram_addr2];

   always #5 clk = ~clk;

   simplecpu_core #(.RESET_PC(8'h00)) dut (
      .wb_clk_i   (clk),
      .wb_rst_n_i (rst_n),
      .run_i      (run),
`ifdef SIMPLECPU_SINGLE_STEP_EN
      .step_i     (step),
`endif
      .ram_addr_o (ram_addr),
      .ram_data_i (ram_data),
      .io_in_i    (io_in),
      .io_out_o   (io_out),
      .a_o        (a),
      .b_o        (b),
      .flag_c_o   (c),
      .flag_z_o   (z),
      .halted_o   (halted)
   );

   simplecpu_core #(.RESET_PC(8'hFF)) dut_ff (
      .wb_clk_i   (clk),
      .wb_rst_n_i (rst_n),
      .run_i      (run),
`ifdef SIMPLECPU_SINGLE_STEP_EN
      .step_i     (1'b0),
`endif
      .ram_addr_o (ram_addr2),
      .ram_data_i (ram_data2),
      .io_in_i    (io_in),
      .io_out_o   (io_out2),
      .a_o        (a2),
      .b_o        (b2),
      .flag_c_o   (c2),
      .flag_z_o   (z2),
      .halted_o   (halted2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   function automatic exp_t mk(input logic [7:0] ea, input logic [7:0] eb, input logic [7:0] epc,
                               input logic [7:0] eout, input logic ec, input logic ez, input int ecyc);
      exp_t e;
      e.a = ea; e.b = eb; e.pc = epc; e.out = eout; e.c = ec; e.z = ez; e.cyc = ecyc;
      return e;
   endfunction

   // Instruction-level interpreter over mem[]; returns 0 if no HLT within the step budget.
   function automatic bit model(input logic [7:0] inval, output exp_t e);
      int pc, ra, rb, rc, rz, rout, cyc, op, opd, s;
      pc = 0; ra = 0; rb = 0; rc = 0; rz = 1; rout = 0; cyc = 0;
      e = mk(0, 0, 0, 0, 0, 0, 0);
      for (int n = 0; n < 300; n++) begin
         op = int'(mem[pc]) / 16;
         pc = (pc + 1) % 256;
         opd = 0;
         if (op == 1 || op == 2 || op == 10 || op == 11 || op == 12) begin
            opd = int'(mem[pc]);
            pc = (pc + 1) % 256;
            cyc += 3;
         end else begin
            cyc += 2;
         end
         case (op)
            1:  begin ra = opd; rz = (ra == 0); end
            2:  rb = opd;
            3:  begin s = ra + rb; rc = (s > 255); ra = s % 256; rz = (ra == 0); end
            4:  begin rc = (ra < rb); ra = (ra - rb + 256) % 256; rz = (ra == 0); end
            5:  begin ra = ra & rb; rz = (ra == 0); end
            6:  begin ra = ra | rb; rz = (ra == 0); end
            7:  begin ra = ra ^ rb; rz = (ra == 0); end
            8:  rout = ra;
            9:  begin ra = int'(inval); rz = (ra == 0); end
            10: pc = opd;
            11: if (rz != 0) pc = opd;
            12: if (rc != 0) pc = opd;
            15: begin
               e = mk(8'(ra), 8'(rb), 8'(pc), 8'(rout), 1'(rc), 1'(rz), cyc);
               return 1'b1;
            end
            default: ;
         endcase
      end
      return 1'b0;
   endfunction

   always @(posedge clk)
      if (mon_active && !halted) cyc_cnt++;

   always @(negedge clk) begin
      if (mon_active && halted) begin
         exp_t e;
         if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL scoreboard_empty: got halt, required a queued expectation");
         end else begin
            e = exp_q.pop_front();
            chk("a",      a,       e.a);
            chk("b",      b,       e.b);
            chk("pc",     ram_addr, e.pc);
            chk("io_out", io_out,  e.out);
            chk("flag_c", c,       e.c);
            chk("flag_z", z,       e.z);
            chk("cycles", cyc_cnt, e.cyc);
         end
         mon_active = 1'b0;
         done = 1'b1;
      end
   end

   task automatic load_prog(input byte_q_t p);
      for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
      for (int i = 0; i < p.size(); i++) mem[i] = p[i];
   endtask

   task automatic gen_prog();
      int n, addr, op;
      for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
      n = $urandom_range(4, 40);
      addr = 0;
      while (addr < n) begin
         op = $urandom_range(0, 14);
         mem[addr] = {op[3:0], 4'($urandom)};
         addr++;
         if (op == 1 || op == 2 || op == 10 || op == 11 || op == 12) begin
            if (op >= 10) mem[addr] = 8'($urandom_range(addr + 1, n + 2));
            else          mem[addr] = 8'($urandom);
            addr++;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      run   = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic check_reset();
      chk("rst_pc",     ram_addr,  8'h00);
      chk("rst_a",      a,         8'h00);
      chk("rst_b",      b,         8'h00);
      chk("rst_io_out", io_out,    8'h00);
      chk("rst_c",      c,         1'b0);
      chk("rst_z",      z,         1'b1);
      chk("rst_halted", halted,    1'b0);
      chk("rst_pc_ff",  ram_addr2, 8'hFF);
   endtask

   task automatic start_and_wait(input exp_t e);
      exp_q.push_back(e);
      cyc_cnt    = 0;
      done       = 1'b0;
      mon_active = 1'b1;
      run        = 1'b1;
      for (int i = 0; i < 3000 && !done; i++) @(negedge clk);
      if (!done) begin
         compared++;
         mismatched++;
         $display("FAIL halt_timeout: got no halt, required halt within 3000 cycles");
         mon_active = 1'b0;
         if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      run = 1'b0;
   endtask

   initial begin
      exp_t e;
      bit   ok;

      for (int i = 0; i < 256; i++) mem2[i] = 8'hF0;
      mem2[255] = 8'h10;
      mem2[0]   = 8'h5A;
      mem2[1]   = 8'hF0;

      // OUT of 5+3, halts at 07
      load_prog('{8'h10, 8'h05, 8'h20, 8'h03, 8'h30, 8'h80, 8'hF0});
      do_reset();
      check_reset();
      start_and_wait(mk(8'h08, 8'h03, 8'h07, 8'h08, 1'b0, 1'b0, 12));

      // Reset PC of FF: operand fetched across the wrap
      chk("ff_a",      a2,        8'h5A);
      chk("ff_pc",     ram_addr2, 8'h02);
      chk("ff_halted", halted2,   1'b1);
      chk("ff_z",      z2,        1'b0);

      // ADD overflow to zero, JC taken
      load_prog('{8'h10, 8'hFF, 8'h20, 8'h01, 8'h30, 8'hC0, 8'h07, 8'h00, 8'hF0});
      do_reset();
      start_and_wait(mk(8'h00, 8'h01, 8'h09, 8'h00, 1'b1, 1'b1, 15));

      // SUB borrow
      load_prog('{8'h10, 8'h02, 8'h20, 8'h03, 8'h40, 8'hF0});
      do_reset();
      start_and_wait(mk(8'hFF, 8'h03, 8'h06, 8'h00, 1'b1, 1'b0, 10));

      // Reset asserted while LDA is in its operand cycle
      load_prog('{8'h10, 8'h55, 8'hF0});
      do_reset();
      run = 1'b1;
      @(negedge clk);
      chk("mid_pc_before", ram_addr, 8'h01);
      rst_n = 1'b0;
      run   = 1'b0;
      @(negedge clk);
      chk("mid_rst_pc",     ram_addr, 8'h00);
      chk("mid_rst_a",      a,        8'h00);
      chk("mid_rst_halted", halted,   1'b0);
      rst_n = 1'b1;
      start_and_wait(mk(8'h55, 8'h00, 8'h03, 8'h00, 1'b0, 1'b0, 5));

`ifdef SIMPLECPU_SINGLE_STEP_EN
      load_prog('{8'h10, 8'h11, 8'h10, 8'h22, 8'hF0});
      do_reset();
      step = 1'b1;
      repeat (10) @(negedge clk);
      chk("step1_a",  a,        8'h11);
      chk("step1_pc", ram_addr, 8'h02);
      step = 1'b0;
      repeat (3) @(negedge clk);
      step = 1'b1;
      repeat (6) @(negedge clk);
      chk("step2_a",  a,        8'h22);
      chk("step2_pc", ram_addr, 8'h04);
      step = 1'b0;
`endif

      for (int t = 0; t < 25; t++) begin
         ok = 1'b0;
         io_in = 8'($urandom);
         while (!ok) begin
            gen_prog();
            ok = model(io_in, e);
         end
         do_reset();
         check_reset();
         start_and_wait(e);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/simplecpu_core.md
SIMPLECPU_CORE -- requirements
Module: simplecpu_core

Interface
REQ-001 RESET_PC, 8'h00, PC value loaded on reset.
REQ-002 wb_clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-003 wb_rst_n_i  input  1  reset, synchronous, active-low.
REQ-004 run_i  input  1  high = core may fetch new instructions.
REQ-005 ram_addr_o  output  8  program RAM byte address; always equals PC.
REQ-006 ram_data_i  input  8  program RAM byte at ram_addr_o; combinational, valid same cycle.
REQ-007 io_in_i  input  8  external input port sampled by IN.
REQ-008 io_out_o  output  8  registered output port written by OUT.
REQ-009 a_o, b_o  output  8 each  accumulator A and register B.
REQ-010 flag_c_o, flag_z_o  output  1 each  carry and zero flags, registered.
REQ-011 halted_o  output  1  high while in HALT state.
REQ-012 step_i  input  1  single-step request; present only when SIMPLECPU_SINGLE_STEP_EN is defined.

Function
REQ-013 ISA: opcode = instruction byte [7:4]; [3:0] ignored; 0x0 NOP, 0x1 LDA imm8, 0x2 LDB imm8, 0x3 ADD, 0x4 SUB, 0x5 AND, 0x6 OR, 0x7 XOR, 0x8 OUT, 0x9 IN, 0xA JMP imm8, 0xB JZ imm8, 0xC JC imm8, 0xF HLT; 0xD/0xE execute as NOP.
REQ-014 States FETCH, OPERAND, EXECUTE, HALT; encoding 2 bits.
REQ-015 FETCH with fetch enabled: latch ram_data_i into IR, PC <= PC+1, go OPERAND if opcode in {1,2,A,B,C}, else EXECUTE; fetch disabled: hold all state.
REQ-016 OPERAND: latch ram_data_i into operand register, PC <= PC+1, go EXECUTE.
REQ-017 EXECUTE: perform operation, go FETCH (HLT: go HALT); one-byte instruction = 2 cycles, two-byte = 3 cycles.
REQ-018 ADD: {C,A} <= A+B (9-bit); SUB: A <= A-B mod 256, C <= 1 when A<B (borrow).
REQ-019 AND/OR/XOR: A <= A op B, C unchanged.
REQ-020 Z <= (new A == 0) after ADD, SUB, AND, OR, XOR, IN, LDA; unchanged otherwise.
REQ-021 LDB, OUT (io_out_o <= A), NOP, JMP leave flags unchanged.
REQ-022 JMP: PC <= operand; JZ/JC: PC <= operand when Z/C is 1, else PC keeps incremented value.
REQ-023 PC increments wrap 8'hFF -> 8'h00, including mid-instruction between opcode and operand.
REQ-024 HALT: hold all registers; exit only via reset; run_i and step_i ignored.
REQ-025 run_i sampled only in FETCH; deassertion during OPERAND/EXECUTE completes current instruction.

Reset
REQ-026 wb_rst_n_i low at a rising edge: PC <= RESET_PC, A, B, IR, operand, io_out_o <= 0, C <= 0, Z <= 1, state <= FETCH, halted_o <= 0.
REQ-027 Reset overrides all activity in any state, including mid-instruction and HALT; no partial register update occurs in that cycle.

Configuration
REQ-028 SIMPLECPU_SINGLE_STEP_EN defined: step_i port exists; fetch enabled in FETCH when run_i=1 or step_i rising edge detected (step_i registered, edge = current & ~previous); one edge = exactly one instruction.
REQ-029 SIMPLECPU_SINGLE_STEP_EN undefined: no step_i port, no edge register; fetch enabled when run_i=1.

Structure
REQ-030 Shared package simplecpu_pkg holds opcode constants, state encoding, RESET_PC default.
REQ-031 Sub-module simplecpu_alu: combinational, inputs A, B, opcode, C_in; outputs result[7:0], C_out, Z_out.
REQ-032 Total RTL 120-400 lines; no memories inside this block.

Verification
REQ-033 Program 10 05 20 03 30 80 F0, run_i=1 -> io_out_o=8'h08, C=0, Z=0, halted_o=1, PC=8'h07.
REQ-034 Program 10 FF 20 01 30 C0 07 00 F0 -> ADD gives A=0, C=1, Z=1; JC taken to 0x07; halt at PC=0x09.
REQ-035 Program 10 02 20 03 40 F0 -> A=8'hFF, C=1 (borrow), Z=0.
REQ-036 RESET_PC=8'hFF, byte 0xFF = 0x10, byte 0x00 = 0x5A, then 0x01 = F0 -> A=8'h5A, PC wraps, halt at 0x02.
REQ-037 Assert wb_rst_n_i low during OPERAND of LDA -> next cycle PC=RESET_PC, A=0, state FETCH.
REQ-038 With SIMPLECPU_SINGLE_STEP_EN, run_i=0, step_i held high 10 cycles -> exactly one instruction executed.
